// File: rtl/qspis_phy.sv
// QSPI slave pad-side front end: oversamples SCK/CSn/SD in the clk_i domain,
// deserialises MOSI into bytes, serialises TX bytes and owns all pad enables.
// SPI mode 0, MSB first, single-bit or quad width.
//
// pad_i layout: [8] sck, [7:4] csn[3:0], [3:0] sd_i[3:0]
// pad_o layout: [7:4] sd_oe[3:0], [3:0] sd_o[3:0]
module qspis_phy #(
  parameter int unsigned CS_IDX      = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [8:0] pad_i,
  output logic [7:0] pad_o,
  input  logic       quad_i,
  input  logic       tx_en_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       cs_active_o,
  output logic       frame_end_o
);

  localparam logic [3:0] CsMask = 4'b0001 << CS_IDX;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  // Synchroniser chain: {sck, csn, sd[3:0]}, plus history for sck/csn edges.
  // Reset to zero so a CS already low at reset release is not seen as a fall.
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [1:0]                  hist_q;
  logic [5:0]                  in_raw;
  logic                        sck_s, csn_s;
  logic [3:0]                  sd_s;
  logic                        sck_rise, sck_fall, cs_fall, cs_rise;

  assign in_raw   = {pad_i[8], |(pad_i[7:4] & CsMask), pad_i[3:0]};
  assign sck_s    = sync_q[SYNC_STAGES-1][5];
  assign csn_s    = sync_q[SYNC_STAGES-1][4];
  assign sd_s     = sync_q[SYNC_STAGES-1][3:0];
  assign sck_rise = sck_s & ~hist_q[1];
  assign sck_fall = ~sck_s & hist_q[1];
  assign cs_fall  = ~csn_s & hist_q[0];
  assign cs_rise  = csn_s & ~hist_q[0];

  // Pad input synchroniser and edge history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= in_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= {sck_s, csn_s};
    end
  end

  logic       quad_q, quad_d;
  logic       txen_q, txen_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       pend_q, pend_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       underrun_q, underrun_d;
  logic       frame_end_q, frame_end_d;
  logic [7:0] pad_q, pad_d;

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: CS edges alone move between idle and active.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next state: RX shift, byte boundary, TX load/shift, holding buffer.
  always_comb begin
    logic       load;
    logic       rx_en;
    logic       last;
    logic       accept;
    logic [7:0] shifted;
    quad_d      = quad_q;
    txen_d      = txen_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_sr_d     = tx_sr_q;
    pend_d      = pend_q;
    hold_d      = hold_q;
    underrun_d  = 1'b0;
    frame_end_d = 1'b0;
    load        = 1'b0;
    accept      = tx_valid_i & ~full_q;
    rx_en       = ~(quad_q & txen_q);
    last        = quad_q ? (cnt_q == 3'd1) : (cnt_q == 3'd7);
    shifted     = quad_q ? {rx_sr_q[3:0], sd_s} : {rx_sr_q[6:0], sd_s[0]};

    if (state_q == StIdle) begin
      if (cs_fall) begin
        quad_d  = quad_i;
        txen_d  = tx_en_i;
        cnt_d   = 3'd0;
        rx_sr_d = 8'h00;
        pend_d  = 1'b0;
        load    = 1'b1;
      end
    end else if (cs_rise) begin
      // Partial byte and pending TX contents are dropped; holding buffer stays.
      cnt_d       = 3'd0;
      rx_sr_d     = 8'h00;
      tx_sr_d     = 8'h00;
      pend_d      = 1'b0;
      frame_end_d = 1'b1;
    end else if (sck_rise) begin
      if (rx_en) rx_sr_d = shifted;
      if (last) begin
        cnt_d  = 3'd0;
        pend_d = 1'b1;
        quad_d = quad_i;
        txen_d = tx_en_i;
        if (rx_en) begin
          rx_data_d  = shifted;
          rx_valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (sck_fall) begin
      if (pend_q) begin
        load   = 1'b1;
        pend_d = 1'b0;
      end else begin
        tx_sr_d = quad_q ? {tx_sr_q[3:0], 4'h0} : {tx_sr_q[6:0], 1'b0};
      end
    end

    // A load always takes the old buffer contents; a same-cycle write refills it.
    if (load) begin
      if (full_q) begin
        tx_sr_d = hold_q;
      end else begin
        tx_sr_d    = 8'hFF;
        underrun_d = 1'b1;
      end
    end
    full_d = (full_q & ~load) | accept;
    if (accept) hold_d = tx_data_i;
  end

  // FSM outputs: pad drive computed from next state so pads update with the state.
  always_comb begin
    pad_d = 8'h00;
    if (state_d == StActive) begin
      if (!quad_d) begin
        pad_d[5] = 1'b1;
        pad_d[1] = tx_sr_d[7];
      end else if (txen_d) begin
        pad_d[7:4] = 4'hF;
        pad_d[3:0] = tx_sr_d[7:4];
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quad_q      <= 1'b0;
      txen_q      <= 1'b0;
      cnt_q       <= 3'd0;
      rx_sr_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_sr_q     <= 8'h00;
      pend_q      <= 1'b0;
      hold_q      <= 8'h00;
      full_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      pad_q       <= 8'h00;
    end else begin
      quad_q      <= quad_d;
      txen_q      <= txen_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_sr_q     <= tx_sr_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      underrun_q  <= underrun_d;
      frame_end_q <= frame_end_d;
      pad_q       <= pad_d;
    end
  end

  assign pad_o         = pad_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~full_q;
  assign tx_underrun_o = underrun_q;
  assign cs_active_o   = (state_q == StActive);
  assign frame_end_o   = frame_end_q;

endmodule

// File: tb/tb_qspis_phy.sv
// Self-checking bench for qspis_phy: scoreboard queues for received bytes and
// for the pad drive expected before each SCK rise.
module tb_qspis_phy;

  localparam int unsigned SyncStages = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic [3:0] csn;
  logic [3:0] sd;
  logic [8:0] pad_i;
  logic [7:0] pad_o;
  logic       quad, tx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       underrun;
  logic       cs_active;
  logic       frame_end;

  assign pad_i = {sck, csn, sd};

  qspis_phy #(
    .CS_IDX     (0),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pad_i        (pad_i),
    .pad_o        (pad_o),
    .quad_i       (quad),
    .tx_en_i      (tx_en),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_underrun_o(underrun),
    .cs_active_o  (cs_active),
    .frame_end_o  (frame_end)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int n_under = 0;
  int n_fe = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_pad[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the RX scoreboard and counts strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          check_eq("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check_eq("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
          check_eq("rx_latency_ok", ((cyc - rise_cyc) <= SyncStages + 3) ? 1 : 0, 1);
        end
      end
      if (underrun) n_under++;
      if (frame_end) n_fe++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCK period; pad drive is compared just before the rise.
  task automatic sck_cycle(input logic [3:0] d);
    sd = d;
    tick(4);
    if (exp_pad.size() > 0) check_eq("pad_before_rise", {24'h0, pad_o}, {24'h0, exp_pad.pop_front()});
    sck = 1'b1;
    rise_cyc = cyc;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic cs_low();
    csn[0] = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    csn[0] = 1'b1;
    tick(8);
  endtask

  task automatic write_tx(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) check_eq("tx_ready_timeout", 0, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  function automatic logic [7:0] single_pad(input logic b);
    return {4'b0010, 2'b00, b, 1'b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] tx_bits;
    logic [7:0]  rxb;
    int          base_u, base_f;
    rst = 1'b1; sck = 1'b0; csn = 4'hF; sd = 4'h0;
    quad = 1'b0; tx_en = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick(3);
    check_eq("rst_pad", {24'h0, pad_o}, 0);
    check_eq("rst_tx_ready", {31'h0, tx_ready}, 1);
    rst = 1'b0;
    tick(4);
    check_eq("idle_rx_valid", {31'h0, rx_valid}, 0);
    check_eq("idle_rx_data", {24'h0, rx_data}, 0);
    check_eq("idle_underrun", {31'h0, underrun}, 0);
    check_eq("idle_cs_active", {31'h0, cs_active}, 0);
    check_eq("idle_frame_end", {31'h0, frame_end}, 0);

    // Single-mode RX of 0xA5; TX underruns so sd1 carries ones.
    cs_low();
    check_eq("cs_active", {31'h0, cs_active}, 1);
    exp_rx.push_back(8'hA5);
    rxb = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      exp_pad.push_back(single_pad(1'b1));
      sck_cycle({3'b000, rxb[i]});
    end
    cs_high();
    check_eq("a5_received", exp_rx.size(), 0);
    check_eq("frame_end_1", n_fe, 1);

    // Quad RX, tx_en=0: nibbles 3 then C, no pad drive.
    quad = 1'b1; tx_en = 1'b0;
    cs_low();
    exp_rx.push_back(8'h3C);
    exp_pad.push_back(8'h00); sck_cycle(4'h3);
    exp_pad.push_back(8'h00); sck_cycle(4'hC);
    cs_high();
    check_eq("3c_received", exp_rx.size(), 0);

    // Single TX of 0x96, 0x0F with a third byte queued to avoid underrun.
    quad = 1'b0;
    write_tx(8'h96);
    check_eq("tx_ready_full", {31'h0, tx_ready}, 0);
    base_u = n_under;
    cs_low();
    check_eq("tx_ready_after_load0", {31'h0, tx_ready}, 1);
    write_tx(8'h0F);
    check_eq("tx_ready_full2", {31'h0, tx_ready}, 0);
    tx_bits = 16'b1001_0110_0000_1111;
    exp_rx.push_back(8'h00);
    exp_rx.push_back(8'h00);
    for (int i = 15; i >= 8; i--) begin
      exp_pad.push_back(single_pad(tx_bits[i]));
      sck_cycle(4'h0);
    end
    tick(4);
    check_eq("tx_ready_after_load1", {31'h0, tx_ready}, 1);
    write_tx(8'h55);
    for (int i = 7; i >= 0; i--) begin
      exp_pad.push_back(single_pad(tx_bits[i]));
      sck_cycle(4'h0);
    end
    cs_high();
    check_eq("single_tx_no_underrun", n_under - base_u, 0);

    // Quad TX with empty buffer: 0xFF and an underrun per load.
    quad = 1'b1; tx_en = 1'b1;
    base_u = n_under;
    cs_low();
    for (int i = 0; i < 4; i++) begin
      exp_pad.push_back(8'hFF);
      sck_cycle(4'h0);
    end
    cs_high();
    check_eq("quad_underruns", n_under - base_u, 3);
    check_eq("quad_idle_pad", {24'h0, pad_o}, 0);

    // CS released after 5 bits, then a clean 0x81 frame.
    quad = 1'b0; tx_en = 1'b0;
    base_f = n_fe;
    cs_low();
    for (int i = 0; i < 5; i++) sck_cycle(4'h1);
    cs_high();
    check_eq("abort_frame_end", n_fe - base_f, 1);
    check_eq("abort_pad", {24'h0, pad_o}, 0);
    cs_low();
    exp_rx.push_back(8'h81);
    rxb = 8'h81;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, rxb[i]});
    cs_high();
    check_eq("81_received", exp_rx.size(), 0);

    // Reset mid-byte in quad TX; frame ignored until a new CS fall.
    quad = 1'b1; tx_en = 1'b1;
    write_tx(8'hA5);
    cs_low();
    exp_pad.push_back(8'hFA);
    sck_cycle(4'h0);
    write_tx(8'h3C);
    tick(2);
    rst = 1'b1;
    #1;
    check_eq("rst_async_pad", {24'h0, pad_o}, 0);
    check_eq("rst_async_ready", {31'h0, tx_ready}, 1);
    tick(3);
    rst = 1'b0;
    base_f = n_fe;
    for (int i = 0; i < 3; i++) begin
      exp_pad.push_back(8'h00);
      sck_cycle(4'h5);
    end
    check_eq("post_rst_cs_active", {31'h0, cs_active}, 0);
    cs_high();
    check_eq("post_rst_no_frame_end", n_fe - base_f, 0);
    check_eq("pad_queue_drained", exp_pad.size(), 0);
    check_eq("rx_queue_drained", exp_rx.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
